// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline register between stages: payload + control bits with valid/ready,
// back-pressure, flush, and an optional second (skid) slot that registers in_ready.
//
//   state | meaning
//   EMPTY | no instruction held; out_valid=0
//   ONE   | main slot holds the head instruction
//   FULL  | main slot holds the head, skid slot holds the next one (SKID=1 only)
module pipe_stage_buffer #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              in_ready_q;
    logic              accept;
    logic              drain;
    logic              load_main;
    logic              load_skid;
    logic              move_skid;

    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign in_ready  = (SKID != 0) ? in_ready_q : (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    // only reachable with the skid slot; without it in_ready blocks this case
                    state_d   = FULL;
                    load_skid = 1'b1;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d   = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            if (load_main) begin
                main_data_q <= in_data;
                main_ctrl_q <= in_ctrl;
            end else if (move_skid) begin
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
            end
            if (load_skid) begin
                skid_data_q <= in_data;
                skid_ctrl_q <= in_ctrl;
            end
        end
    end

endmodule
